// File: rtl/intctl_pkg.sv
// intctl_pkg: shared constants and helpers for the intctl interrupt controller.
//   IDX_*           register word indices (address bits [31:2])
//   RDATA_UNMAPPED  read data returned for unmapped addresses
//   RESP_OKAY       AXI response code used for every transfer
//   lowest_set()    priority encoder returning {valid, index[4:0]}
package intctl_pkg;

  localparam logic [29:0] IDX_RAW     = 30'd0;
  localparam logic [29:0] IDX_ENABLE  = 30'd1;
  localparam logic [29:0] IDX_MODE    = 30'd2;
  localparam logic [29:0] IDX_PENDING = 30'd3;
  localparam logic [29:0] IDX_CLAIM   = 30'd4;

  localparam logic [31:0] RDATA_UNMAPPED = 32'h5555_5555;
  localparam logic [1:0]  RESP_OKAY      = 2'b00;

  // Returns {1'b1, index} of the lowest set bit, or all zeros when vec == 0.
  function automatic logic [5:0] lowest_set(input logic [31:0] vec);
    logic [5:0] res;
    res = '0;
    for (int unsigned i = 32; i > 0; i--) begin
      if (vec[i-1]) begin
        res = {1'b1, 5'(i - 1)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/intctl_irq_sync_edge.sv
// irq_sync_edge: per-source 2-flop synchronizer plus a delayed copy for
// rising-edge detection.
//   clk_i    clock
//   rst_i    synchronous active-high reset
//   irq_i    asynchronous interrupt line
//   level_o  synchronized level (sync2)
//   rise_o   sync2 & ~sync2_d
module irq_sync_edge
  import intctl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic irq_i,
  output logic level_o,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic sync2_dly_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync2_dly_q <= 1'b0;
    end else begin
      sync1_q     <= irq_i;
      sync2_q     <= sync1_q;
      sync2_dly_q <= sync2_q;
    end
  end

  assign level_o = sync2_q;
  assign rise_o  = sync2_q & ~sync2_dly_q;

endmodule

// File: rtl/intctl.sv
// intctl: AXI4-Lite interrupt controller.
//   aclk / areset        clock, synchronous active-high reset
//   irq_in[NUM_IRQ]      peripheral interrupt lines (asynchronous levels)
//   irq_out              registered |(PENDING & ENABLE) to the CPU
//   s_axi_ar*/r*         read channel, one read outstanding
//   s_axi_aw*/w*/b*      write channel, address and data accepted together
// Registers (addr[31:2]): 0 RAW, 1 ENABLE, 2 MODE, 3 PENDING (W1C), 4 CLAIM.
module intctl
  import intctl_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out,

  input  logic               s_axi_arvalid,
  output logic               s_axi_arready,
  input  logic [31:0]        s_axi_araddr,
  input  logic [2:0]         s_axi_arprot,
  output logic               s_axi_rvalid,
  input  logic               s_axi_rready,
  output logic [31:0]        s_axi_rdata,
  output logic [1:0]         s_axi_rresp,

  input  logic               s_axi_awvalid,
  output logic               s_axi_awready,
  input  logic [31:0]        s_axi_awaddr,
  input  logic [2:0]         s_axi_awprot,
  input  logic               s_axi_wvalid,
  output logic               s_axi_wready,
  input  logic [31:0]        s_axi_wdata,
  input  logic [3:0]         s_axi_wstrb,
  output logic               s_axi_bvalid,
  input  logic               s_axi_bready,
  output logic [1:0]         s_axi_bresp
);

  logic [NUM_IRQ-1:0] raw;
  logic [NUM_IRQ-1:0] rise;

  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] mode_q, mode_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mode_chg;
  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] active;
  logic               irq_q;
  logic               rvalid_q, rvalid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               bvalid_q, bvalid_d;

  logic               rd_acc;
  logic               wr_acc;
  logic [29:0]        ridx;
  logic [29:0]        widx;
  logic [31:0]        wmask_full;
  logic [NUM_IRQ-1:0] wmask;
  logic [NUM_IRQ-1:0] wbits;
  logic [5:0]         claim_sel;
  logic [31:0]        claim;
  logic [31:0]        rd_val;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_src
    irq_sync_edge u_sync (
      .clk_i   (aclk),
      .rst_i   (areset),
      .irq_i   (irq_in[g]),
      .level_o (raw[g]),
      .rise_o  (rise[g])
    );
  end

  assign rd_acc = s_axi_arvalid & ~rvalid_q;
  assign wr_acc = s_axi_awvalid & s_axi_wvalid & ~bvalid_q;

  assign s_axi_arready = ~rvalid_q;
  assign s_axi_awready = wr_acc;
  assign s_axi_wready  = wr_acc;

  assign ridx = s_axi_araddr[31:2];
  assign widx = s_axi_awaddr[31:2];

  assign wmask_full = {{8{s_axi_wstrb[3]}}, {8{s_axi_wstrb[2]}},
                       {8{s_axi_wstrb[1]}}, {8{s_axi_wstrb[0]}}};
  assign wmask      = wmask_full[NUM_IRQ-1:0];
  assign wbits      = s_axi_wdata[NUM_IRQ-1:0];

  assign active    = pending_q & enable_q;
  assign claim_sel = lowest_set(32'(active));
  assign claim     = {claim_sel[5], 26'd0, claim_sel[4:0]};

  always_comb begin
    rd_val = RDATA_UNMAPPED;
    case (ridx)
      IDX_RAW:     rd_val = 32'(raw);
      IDX_ENABLE:  rd_val = 32'(enable_q);
      IDX_MODE:    rd_val = 32'(mode_q);
      IDX_PENDING: rd_val = 32'(pending_q);
      IDX_CLAIM:   rd_val = claim;
      default:     rd_val = RDATA_UNMAPPED;
    endcase
  end

  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    mode_chg = '0;
    w1c      = '0;
    if (wr_acc) begin
      case (widx)
        IDX_ENABLE: enable_d = (enable_q & ~wmask) | (wbits & wmask);
        IDX_MODE: begin
          mode_d   = (mode_q & ~wmask) | (wbits & wmask);
          mode_chg = mode_q ^ mode_d;
        end
        IDX_PENDING: w1c = wbits & wmask;
        default: ;
      endcase
    end

    // Edge sources: a new rise beats a W1C in the same cycle. Level sources
    // just follow sync2. A mode change then clears the affected bits,
    // overriding both.
    pending_d = ((mode_q & (rise | (pending_q & ~w1c))) | (~mode_q & raw)) & ~mode_chg;

    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (rd_acc) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
    end else if (s_axi_rready) begin
      rvalid_d = 1'b0;
    end

    bvalid_d = bvalid_q;
    if (wr_acc) begin
      bvalid_d = 1'b1;
    end else if (s_axi_bready) begin
      bvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      enable_q  <= '0;
      mode_q    <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      bvalid_q  <= 1'b0;
    end else begin
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      irq_q     <= |active;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      bvalid_q  <= bvalid_d;
    end
  end

  assign irq_out      = irq_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = RESP_OKAY;
  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = RESP_OKAY;

  logic unused_bits;
  assign unused_bits = ^{s_axi_arprot, s_axi_awprot, s_axi_araddr[1:0],
                         s_axi_awaddr[1:0], wmask_full[31:NUM_IRQ],
                         s_axi_wdata[31:NUM_IRQ]};

endmodule
